// File: rtl/writeback_arbiter_pkg.sv
// Shared register-file types: architectural register names, the result
// record produced by functional units, and the register-file write record.
package writeback_arbiter_pkg;

  typedef enum logic [4:0] {
    REG_ZERO, REG_X1,  REG_X2,  REG_X3,  REG_X4,  REG_X5,  REG_X6,  REG_X7,
    REG_X8,   REG_X9,  REG_X10, REG_X11, REG_X12, REG_X13, REG_X14, REG_X15,
    REG_X16,  REG_X17, REG_X18, REG_X19, REG_X20, REG_X21, REG_X22, REG_X23,
    REG_X24,  REG_X25, REG_X26, REG_X27, REG_X28, REG_X29, REG_X30, REG_X31
  } register_e;

  typedef struct packed {
    register_e   address;
    logic [31:0] data;
  } writeback_result_t;

  typedef struct packed {
    logic        enable;
    register_e   address;
    logic [31:0] data;
  } register_file_write_t;

endpackage

// File: rtl/writeback_fifo.sv
// Per-source result FIFO.
//   clk_i/rst_ni : clock, synchronous active-low reset
//   push_i/data_i: enqueue (ignored when full)
//   pop_i        : dequeue head (ignored when empty)
//   empty_o/head_o/count_o : status, oldest entry, occupancy
//   entries_o/entry_valid_o: raw storage view for simulation checks
module writeback_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter  int unsigned Depth = 2,
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            push_i,
  input  writeback_result_t               data_i,
  input  logic                            pop_i,
  output logic                            empty_o,
  output writeback_result_t               head_o,
  output logic [CntW-1:0]                 count_o,
  output writeback_result_t [Depth-1:0]   entries_o,
  output logic [Depth-1:0]                entry_valid_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  writeback_result_t r_mem [Depth];
  logic [PtrW-1:0]   r_rd;
  logic [PtrW-1:0]   r_wr;
  logic [CntW-1:0]   r_count;
  logic [Depth-1:0]  r_valid;
  logic              w_full;
  logic              w_push;
  logic              w_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full  = (r_count == CntW'(Depth));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i && !w_full;
  assign w_pop   = pop_i && !empty_o;
  assign head_o  = r_mem[r_rd];
  assign count_o = r_count;
  assign entry_valid_o = r_valid;

  always_comb begin
    entries_o = '0;
    for (int unsigned j = 0; j < Depth; j++) begin
      entries_o[j] = r_mem[j];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_pop) begin
        r_rd           <= ptr_inc(r_rd);
        r_valid[r_rd]  <= 1'b0;
      end
      if (w_push) begin
        r_mem[r_wr]    <= data_i;
        r_wr           <= ptr_inc(r_wr);
        r_valid[r_wr]  <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(push_i && w_full))
        else $error("writeback_fifo: push while full");
    end
  end
`endif

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback stage: buffers results from SourceCount functional units,
// retires one per cycle round-robin into the register-file write port,
// and counts retired results.
//   clk_i/rst_ni    : clock, synchronous active-low reset
//   result_valid_i  : per-source result present
//   result_ready_o  : per-source FIFO has space (registered occupancy only)
//   result_i        : per-source {address, data}
//   write_o         : registered {enable, address, data} to write port 0
//   retire_count_o  : 64-bit count of retired results (feeds minstret)
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned SourceCount = 3,
  parameter int unsigned FifoDepth   = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic              [SourceCount-1:0] result_valid_i,
  output logic              [SourceCount-1:0] result_ready_o,
  input  writeback_result_t [SourceCount-1:0] result_i,
  output register_file_write_t                write_o,
  output logic [63:0]                         retire_count_o
);

  localparam int unsigned GW   = (SourceCount > 1) ? $clog2(SourceCount) : 1;
  localparam int unsigned CntW = $clog2(FifoDepth + 1);

  logic              [SourceCount-1:0] w_empty;
  logic              [SourceCount-1:0] w_pop;
  writeback_result_t                   w_heads   [SourceCount];
  logic [CntW-1:0]                     w_count   [SourceCount];
  writeback_result_t [FifoDepth-1:0]   w_entries [SourceCount];
  logic [FifoDepth-1:0]                w_evalid  [SourceCount];

  logic [GW-1:0]     r_last_grant;
  logic [GW-1:0]     w_winner;
  logic              w_found;
  writeback_result_t w_head;

  for (genvar i = 0; i < SourceCount; i++) begin : g_src
    assign result_ready_o[i] = (w_count[i] < CntW'(FifoDepth));
    assign w_pop[i]          = w_found && (w_winner == GW'(i));

    writeback_fifo #(.Depth(FifoDepth)) u_fifo (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .push_i        (result_valid_i[i] && result_ready_o[i]),
      .data_i        (result_i[i]),
      .pop_i         (w_pop[i]),
      .empty_o       (w_empty[i]),
      .head_o        (w_heads[i]),
      .count_o       (w_count[i]),
      .entries_o     (w_entries[i]),
      .entry_valid_o (w_evalid[i])
    );
  end

  // Scan sources starting just after the last grant; first non-empty wins.
  always_comb begin
    int unsigned idx;
    w_found  = 1'b0;
    w_winner = '0;
    idx      = 0;
    for (int unsigned k = 1; k <= SourceCount; k++) begin
      idx = (32'(r_last_grant) + k) % SourceCount;
      if (!w_found && !w_empty[idx]) begin
        w_found  = 1'b1;
        w_winner = GW'(idx);
      end
    end
  end

  assign w_head = w_heads[w_winner];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      write_o        <= '0;
      retire_count_o <= '0;
      r_last_grant   <= GW'(SourceCount - 1);
    end else if (w_found) begin
      write_o.enable  <= (w_head.address != REG_ZERO);
      write_o.address <= w_head.address;
      write_o.data    <= w_head.data;
      retire_count_o  <= retire_count_o + 64'd1;
      r_last_grant    <= w_winner;
    end else begin
      write_o.enable  <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(write_o.enable && write_o.address == REG_ZERO))
        else $error("writeback_arbiter: write enable to x0");
      for (int unsigned a = 0; a < SourceCount; a++) begin
        for (int unsigned b = a + 1; b < SourceCount; b++) begin
          for (int unsigned x = 0; x < FifoDepth; x++) begin
            for (int unsigned y = 0; y < FifoDepth; y++) begin
              assert (!(w_evalid[a][x] && w_evalid[b][y] &&
                        w_entries[a][x].address != REG_ZERO &&
                        w_entries[a][x].address == w_entries[b][y].address))
                else $error("writeback_arbiter: same register in flight from two sources");
            end
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic              [2:0] valid;
  logic              [2:0] ready;
  writeback_result_t [2:0] result;
  register_file_write_t    wr;
  logic [63:0]             rcnt;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_retire;
  register_file_write_t exp_wr;

  always #5 clk = ~clk;

  writeback_arbiter #(.SourceCount(3), .FifoDepth(2)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .result_valid_i (valid),
    .result_ready_o (ready),
    .result_i       (result),
    .write_o        (wr),
    .retire_count_o (rcnt)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    valid = '0;
    tick();
    rst_n = 1'b1;
    exp_retire = '0;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    valid  = 3'b111;
    result[0] = '{address: REG_X1, data: 32'h11};
    result[1] = '{address: REG_X2, data: 32'h22};
    result[2] = '{address: REG_X3, data: 32'h33};
    tick();
    tick();
    rst_n = 1'b1;
    valid = '0;
    exp_retire = '0;
    checks++;
    if (ready !== 3'b111) begin errors++; $display("FAIL reset_ready: got %b expected %b", ready, 3'b111); end
    checks++;
    if (wr !== register_file_write_t'('0)) begin errors++; $display("FAIL reset_write: got %h expected 0", wr); end
    checks++;
    if (rcnt !== 64'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", rcnt); end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (wr.enable !== 1'b0 || rcnt !== 64'd0) begin
        errors++; $display("FAIL reset_no_push: enable=%b count=%0d expected 0/0", wr.enable, rcnt);
      end
    end
  endtask

  task automatic test_single();
    apply_reset();
    valid = 3'b001;
    result[0] = '{address: REG_X5, data: 32'hDEADBEEF};
    tick();
    valid = '0;
    checks++;
    if (wr.enable !== 1'b0) begin errors++; $display("FAIL single_c2: enable=%b expected 0", wr.enable); end
    tick();
    exp_wr = '{enable: 1'b1, address: REG_X5, data: 32'hDEADBEEF};
    checks++;
    if (wr !== exp_wr) begin errors++; $display("FAIL single_c3: got %h expected %h", wr, exp_wr); end
    tick();
    checks++;
    if (wr.enable !== 1'b0) begin errors++; $display("FAIL single_c4_en: enable=%b expected 0", wr.enable); end
    checks++;
    if (rcnt !== 64'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", rcnt); end
  endtask

  task automatic test_simultaneous();
    register_file_write_t exp_seq [5];
    exp_seq[0] = '{enable: 1'b1, address: REG_X1, data: 32'd1};
    exp_seq[1] = '{enable: 1'b1, address: REG_X2, data: 32'd2};
    exp_seq[2] = '{enable: 1'b1, address: REG_X3, data: 32'd3};
    exp_seq[3] = '{enable: 1'b1, address: REG_X7, data: 32'd7};
    exp_seq[4] = '{enable: 1'b1, address: REG_X8, data: 32'd8};
    apply_reset();
    valid = 3'b111;
    result[0] = '{address: REG_X1, data: 32'd1};
    result[1] = '{address: REG_X2, data: 32'd2};
    result[2] = '{address: REG_X3, data: 32'd3};
    tick();
    valid = '0;
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (wr !== exp_seq[k]) begin errors++; $display("FAIL simul_w%0d: got %h expected %h", k, wr, exp_seq[k]); end
      if (k == 2) begin
        valid = 3'b011;
        result[0] = '{address: REG_X7, data: 32'd7};
        result[1] = '{address: REG_X8, data: 32'd8};
      end
      tick();
    end
    valid = '0;
    checks++;
    if (rcnt !== 64'd3) begin errors++; $display("FAIL simul_count3: got %0d expected 3", rcnt); end
    tick();
    checks++;
    if (wr !== exp_seq[3]) begin errors++; $display("FAIL simul_rr0: got %h expected %h", wr, exp_seq[3]); end
    tick();
    checks++;
    if (wr !== exp_seq[4]) begin errors++; $display("FAIL simul_rr1: got %h expected %h", wr, exp_seq[4]); end
    checks++;
    if (rcnt !== 64'd5) begin errors++; $display("FAIL simul_count5: got %0d expected 5", rcnt); end
  endtask

  task automatic test_back_to_back();
    int pushed [2];
    int popped [2];
    int writes;
    int cyc;
    logic [2:0] last_valid;
    logic [2:0] last_ready;
    int src;
    int idx;
    register_file_write_t exp_b;
    apply_reset();
    pushed = '{0, 0};
    popped = '{0, 0};
    writes = 0;
    last_valid = '0;
    last_ready = '0;
    cyc = 0;
    while (writes < 10 && cyc < 60) begin
      for (int s = 0; s < 2; s++)
        if (last_valid[s] && last_ready[s]) pushed[s]++;
      if (wr.enable === 1'b1) begin
        // expected order alternates src0, src1 with per-source index writes/2
        src = writes % 2;
        idx = writes / 2;
        exp_b.enable  = 1'b1;
        exp_b.address = (src == 0) ? register_e'(5'(10 + idx)) : register_e'(5'(20 + idx));
        exp_b.data    = (src == 0) ? 32'hA000_0000 + 32'(idx) : 32'hB000_0000 + 32'(idx);
        checks++;
        if (wr !== exp_b) begin errors++; $display("FAIL b2b_write%0d: got %h expected %h", writes, wr, exp_b); end
        if (wr.address >= REG_X20) popped[1]++; else popped[0]++;
        writes++;
      end
      for (int s = 0; s < 2; s++) begin
        checks++;
        if (ready[s] !== ((pushed[s] - popped[s]) < 2)) begin
          errors++; $display("FAIL b2b_ready%0d: got %b expected %b (occupancy %0d)", s, ready[s], (pushed[s] - popped[s]) < 2, pushed[s] - popped[s]);
        end
      end
      valid[0] = (pushed[0] < 5);
      valid[1] = (pushed[1] < 5);
      valid[2] = 1'b0;
      result[0] = '{address: register_e'(5'(10 + pushed[0])), data: 32'hA000_0000 + 32'(pushed[0])};
      result[1] = '{address: register_e'(5'(20 + pushed[1])), data: 32'hB000_0000 + 32'(pushed[1])};
      last_valid = valid;
      last_ready = ready;
      if (writes < 10) tick();
      cyc++;
    end
    valid = '0;
    checks++;
    if (writes != 10) begin errors++; $display("FAIL b2b_drain: got %0d writes expected 10", writes); end
    checks++;
    if (rcnt !== 64'd10) begin errors++; $display("FAIL b2b_count: got %0d expected 10", rcnt); end
    tick();
    checks++;
    if (wr.enable !== 1'b0) begin errors++; $display("FAIL b2b_idle: enable=%b expected 0", wr.enable); end
    exp_retire = 64'd10;
  endtask

  task automatic test_x0();
    valid = 3'b100;
    result[2] = '{address: REG_ZERO, data: 32'h1234};
    tick();
    valid = '0;
    checks++;
    if (rcnt !== exp_retire) begin errors++; $display("FAIL x0_pre_count: got %0d expected %0d", rcnt, exp_retire); end
    tick();
    exp_wr = '{enable: 1'b0, address: REG_ZERO, data: 32'h1234};
    checks++;
    if (wr !== exp_wr) begin errors++; $display("FAIL x0_write: got %h expected %h", wr, exp_wr); end
    checks++;
    if (rcnt !== exp_retire + 64'd1) begin errors++; $display("FAIL x0_count: got %0d expected %0d", rcnt, exp_retire + 64'd1); end
  endtask

  task automatic test_reset_mid();
    valid = 3'b111;
    result[0] = '{address: REG_X1, data: 32'h1};
    result[1] = '{address: REG_X2, data: 32'h2};
    result[2] = '{address: REG_X3, data: 32'h3};
    tick();
    result[0] = '{address: REG_X4, data: 32'h4};
    result[1] = '{address: REG_X5, data: 32'h5};
    result[2] = '{address: REG_X6, data: 32'h6};
    tick();
    valid = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (ready !== 3'b111) begin errors++; $display("FAIL mid_ready: got %b expected %b", ready, 3'b111); end
    checks++;
    if (rcnt !== 64'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", rcnt); end
    checks++;
    if (wr !== register_file_write_t'('0)) begin errors++; $display("FAIL mid_write: got %h expected 0", wr); end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (wr.enable !== 1'b0) begin errors++; $display("FAIL mid_quiet%0d: enable=%b expected 0", c, wr.enable); end
    end
    valid = 3'b010;
    result[1] = '{address: REG_X9, data: 32'h9};
    tick();
    valid = '0;
    tick();
    exp_wr = '{enable: 1'b1, address: REG_X9, data: 32'h9};
    checks++;
    if (wr !== exp_wr) begin errors++; $display("FAIL mid_recover: got %h expected %h", wr, exp_wr); end
    checks++;
    if (rcnt !== 64'd1) begin errors++; $display("FAIL mid_recover_count: got %0d expected 1", rcnt); end
  endtask

  initial begin
    rst_n = 1'b0;
    valid = '0;
    result = '0;
    exp_retire = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_back_to_back();
    test_x0();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
